// File: rtl/data_stream_pkg.sv
// Shared types and constants for the framed PRBS serial stream.
// Frame layout: SYNC (8) | CNT (8) | PAYLOAD (PAYLOAD_BITS) | PARITY (1).
`timescale 1ns/1ps
package data_stream_pkg;

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_CNT     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_PARITY  = 2'd3
  } state_t;

  localparam int SYNC_LEN   = 8;
  localparam int CNT_LEN    = 8;
  localparam int PARITY_LEN = 1;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;
  localparam logic [6:0] DEFAULT_PRBS_SEED = 7'h7F;

  // Number of bits the stream spends in a given field.
  function automatic int field_len(input state_t s, input int payload_bits);
    int len;
    len = 0;
    case (s)
      S_SYNC:    len = SYNC_LEN;
      S_CNT:     len = CNT_LEN;
      S_PAYLOAD: len = payload_bits;
      S_PARITY:  len = PARITY_LEN;
      default:   len = PARITY_LEN;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/data_stream_prbs7_gen.sv
// PRBS-7 source (x^7 + x^6 + 1); the MSB is the output bit and the register
// only shifts when enabled, so the sequence carries across frames.
`timescale 1ns/1ps
module prbs7_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] seed,
  output logic       bit_out
);

  logic [6:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= seed;
    end else if (enable) begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  end

  assign bit_out = lfsr[6];

endmodule

// File: rtl/data_stream.sv
// Continuous framed serial stream: SYNC, frame counter, PRBS payload and an
// even-parity bit over CNT+PAYLOAD, emitted back-to-back on a registered output.
`timescale 1ns/1ps
module data_stream
  import data_stream_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD    = DEFAULT_SYNC_WORD,
  parameter int         PAYLOAD_BITS = 16,
  parameter logic [6:0] PRBS_SEED    = DEFAULT_PRBS_SEED
) (
  input  logic clk,
  input  logic rst,
  output logic data_out
);

  localparam int MAX_FIELD = (PAYLOAD_BITS > CNT_LEN) ? PAYLOAD_BITS : CNT_LEN;
  localparam int IDX_W     = $clog2(MAX_FIELD);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       frame_cnt;
  logic             parity_acc;

  logic             prbs_bit;
  logic             prbs_en;
  logic             cur_bit;
  logic [IDX_W-1:0] last_idx;
  state_t           next_field;

  prbs7_gen u_prbs (
    .clk     (clk),
    .rst     (rst),
    .enable  (prbs_en),
    .seed    (PRBS_SEED),
    .bit_out (prbs_bit)
  );

  // Bit that the next rising edge will drive onto data_out.
  always_comb begin
    cur_bit    = 1'b0;
    prbs_en    = 1'b0;
    next_field = S_SYNC;
    last_idx   = IDX_W'(field_len(state, PAYLOAD_BITS) - 1);
    case (state)
      S_SYNC: begin
        cur_bit    = SYNC_WORD[3'd7 - idx[2:0]];
        next_field = S_CNT;
      end
      S_CNT: begin
        cur_bit    = frame_cnt[3'd7 - idx[2:0]];
        next_field = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        cur_bit    = prbs_bit;
        prbs_en    = 1'b1;
        next_field = S_PARITY;
      end
      S_PARITY: begin
        cur_bit    = parity_acc;
        next_field = S_SYNC;
      end
      default: begin
        cur_bit    = 1'b0;
        next_field = S_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_SYNC;
      idx        <= '0;
      frame_cnt  <= 8'd0;
      parity_acc <= 1'b0;
      data_out   <= 1'b0;
    end else begin
      data_out <= cur_bit;

      case (state)
        S_CNT, S_PAYLOAD: parity_acc <= parity_acc ^ cur_bit;
        S_PARITY: begin
          parity_acc <= 1'b0;
          frame_cnt  <= frame_cnt + 8'd1;
        end
        default: parity_acc <= parity_acc;
      endcase

      if (idx == last_idx) begin
        idx   <= '0;
        state <= next_field;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_stream.sv
// Bench for data_stream: expected stream bits come from a frame-level model
// (PRBS recurrence array plus per-frame assembly) and are checked by a monitor.
`timescale 1ns/1ps
module tb_data_stream;

  localparam logic [7:0] SYNC_WORD    = 8'hA5;
  localparam int         PAYLOAD_BITS = 16;
  localparam logic [6:0] PRBS_SEED    = 7'h7F;
  localparam int         FRAME_LEN    = 8 + 8 + PAYLOAD_BITS + 1;
  localparam int         PRBS_LEN     = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_out;

  data_stream #(
    .SYNC_WORD    (SYNC_WORD),
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .PRBS_SEED    (PRBS_SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_out (data_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic prbs_seq [PRBS_LEN];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stream_n = 0;

  logic [0:0] exp_q[$];
  int         pos_q[$];

  function automatic logic exp_bit(input int n);
    int f, p;
    logic [7:0] cnt;
    logic par;
    f   = n / FRAME_LEN;
    p   = n % FRAME_LEN;
    cnt = 8'(f % 256);
    if (p < 8) return SYNC_WORD[7 - p];
    if (p < 16) return cnt[15 - p];
    if (p < 16 + PAYLOAD_BITS) return prbs_seq[f * PAYLOAD_BITS + p - 16];
    par = ^cnt;
    for (int j = 0; j < PAYLOAD_BITS; j++) par = par ^ prbs_seq[f * PAYLOAD_BITS + j];
    return par;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_bits(input int count);
    repeat (count) begin
      @(posedge clk);
      exp_q.push_back(exp_bit(stream_n));
      pos_q.push_back(stream_n);
      stream_n++;
    end
  endtask

  // Called between edges; asserts reset, checks the async clear, holds, releases.
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    check("async_reset_clear", {15'd0, data_out}, 16'd0);
    repeat (cycles) begin
      @(posedge clk);
      exp_q.push_back(1'b0);
      pos_q.push_back(-1);
    end
    @(negedge clk);
    #2;
    rst      = 1'b1;
    stream_n = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       m_exp;
  int         m_n;
  int         m_p;
  logic [7:0] m_sync;
  logic [7:0] m_cnt;
  logic       m_xor;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_n   = pos_q.pop_front();
      if (m_n < 0) begin
        check("held_reset_out", {15'd0, data_out}, 16'd0);
      end else begin
        check("stream_bit", {15'd0, data_out}, {15'd0, m_exp});
        m_p = m_n % FRAME_LEN;
        if (m_p == 0) begin
          m_sync = 8'd0;
          m_cnt  = 8'd0;
          m_xor  = 1'b0;
        end
        if (m_p < 8) m_sync = {m_sync[6:0], data_out};
        else if (m_p < 16) m_cnt = {m_cnt[6:0], data_out};
        if (m_p >= 8) m_xor = m_xor ^ data_out;
        if (m_p == FRAME_LEN - 1) begin
          check("frame_sync", {8'd0, m_sync}, {8'd0, SYNC_WORD});
          check("frame_cnt", {8'd0, m_cnt}, {8'd0, 8'((m_n / FRAME_LEN) % 256)});
          check("frame_parity_xor", {15'd0, m_xor}, 16'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 7; i++) prbs_seq[i] = PRBS_SEED[6 - i];
    for (int k = 0; k + 7 < PRBS_LEN; k++) prbs_seq[k + 7] = prbs_seq[k] ^ prbs_seq[k + 1];

    #2;
    do_reset(10);

    // First frame, then 256 more to cover counter wrap.
    run_bits(FRAME_LEN);
    run_bits(FRAME_LEN * 256);
    @(negedge clk);
    #1;

    // Reset in the middle of frame index 2, bit 20; restart must be identical.
    do_reset(3);
    run_bits(2 * FRAME_LEN + 21);
    @(negedge clk);
    #1;
    do_reset(10);
    run_bits(FRAME_LEN);
    @(negedge clk);
    #1;

    // Randomized reset points and hold times.
    for (int r = 0; r < 8; r++) begin
      run_bits($urandom_range(5, 150));
      @(negedge clk);
      #1;
      do_reset($urandom_range(1, 12));
      run_bits(FRAME_LEN + $urandom_range(0, 40));
      @(negedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
